// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer between a pixel source, a 3x3 line buffer and a convolution engine.
// Build macro CNN_SEQ_FLUSH_EN adds a WIDTH+1 zero-pixel flush phase before DONE.
module cnn_frame_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 28,
  parameter int HEIGHT     = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic [DATA_WIDTH-1:0] lb_pixel,
  output logic                  lb_valid,
  input  logic                  lb_window_valid,
  output logic                  conv_valid,
  input  logic                  conv_ready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           win_cnt
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int PIX_W = (TOTAL > 1)  ? $clog2(TOTAL)  : 1;
  localparam int COL_W = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(TOTAL - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

`ifdef CNN_SEQ_FLUSH_EN
  localparam state_t END_STATE = FLUSH;
`else
  localparam state_t END_STATE = DONE;
`endif

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t state;
  state_t state_nxt;

  logic [PIX_W-1:0] pix_cnt;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             in_frame;
  logic             accept;
  logic             last_pix;
  logic             frame_start;
  logic             inject;

  assign in_frame    = (state == FILL) || (state == STREAM);
  assign frame_start = (state == IDLE) && start;
  // abort kills the handshake in its own cycle so nothing is half-accepted
  assign src_ready   = in_frame && !abort && (!lb_window_valid || conv_ready);
  assign accept      = src_valid && src_ready;
  assign last_pix    = (pix_cnt == PIX_LAST) && (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);

`ifdef CNN_SEQ_FLUSH_EN
  localparam int FL_W = $clog2(WIDTH + 2);
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(WIDTH);

  logic [FL_W-1:0] flush_cnt;

  assign inject = (state == FLUSH) && !abort && (!lb_window_valid || conv_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (frame_start) begin
      flush_cnt <= '0;
    end else if (inject) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign inject = 1'b0;
`endif

  always_comb begin
    lb_valid   = accept || inject;
    lb_pixel   = accept ? src_data : '0;
    conv_valid = lb_valid && lb_window_valid;
    busy       = in_frame || (state == FLUSH);
    done       = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        // a tiny frame can end before the window ever becomes valid
        if (accept && last_pix)             state_nxt = END_STATE;
        else if (accept && lb_window_valid) state_nxt = STREAM;
      end
      STREAM: begin
        if (accept && last_pix) state_nxt = END_STATE;
      end
      FLUSH: begin
`ifdef CNN_SEQ_FLUSH_EN
        if (inject && (flush_cnt == FLUSH_LAST)) state_nxt = DONE;
`else
        state_nxt = IDLE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      win_cnt <= '0;
    end else if (frame_start) begin
      pix_cnt <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      win_cnt <= '0;
    end else begin
      if (accept) begin
        pix_cnt <= pix_cnt + 1'b1;
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      if (conv_valid) win_cnt <= sat_inc16(win_cnt);
    end
  end

endmodule
